// File: rtl/tabla_scan_ctrl.sv
// Exhaustive sweep controller for a 3- or 4-input combinational truth-table block.
// Define TABLA_SCAN_EARLY_STOP_EN to end the sweep at the first mismatching vector.
module tabla_scan_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        tbl_y,
    output logic [3:0]  tbl_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth,
    output logic        match,
    output logic        err_valid,
    output logic [3:0]  err_idx
);

    localparam logic [3:0] LAST_IDX    = 4'((1 << N_IN) - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [3:0]  idx;
    logic [3:0]  settleCnt;
    logic [15:0] expLatched;
    logic        sampleMiss;
    logic        lastVec;

    assign sampleMiss = (state == SAMPLE) && (tbl_y != expLatched[idx]);
    assign lastVec    = (idx == LAST_IDX);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) nextState = DRIVE;
            end
            DRIVE: begin
                if (settleCnt == SETTLE_LAST) nextState = SAMPLE;
            end
            SAMPLE: begin
`ifdef TABLA_SCAN_EARLY_STOP_EN
                if (lastVec || (sampleMiss && !err_valid)) nextState = DONE;
                else                                       nextState = DRIVE;
`else
                if (lastVec) nextState = DONE;
                else         nextState = DRIVE;
`endif
            end
            DONE: begin
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign tbl_in = ((state == DRIVE) || (state == SAMPLE)) ? idx : 4'd0;
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= 4'd0;
            settleCnt  <= 4'd0;
            expLatched <= 16'd0;
            truth      <= 16'd0;
            match      <= 1'b0;
            err_valid  <= 1'b0;
            err_idx    <= 4'd0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        expLatched <= expected;
                        truth      <= 16'd0;
                        match      <= 1'b0;
                        err_valid  <= 1'b0;
                        err_idx    <= 4'd0;
                        idx        <= 4'd0;
                        settleCnt  <= 4'd0;
                    end
                end
                DRIVE: begin
                    settleCnt <= settleCnt + 4'd1;
                end
                SAMPLE: begin
                    truth[idx] <= tbl_y;
                    if (sampleMiss && !err_valid) begin
                        err_valid <= 1'b1;
                        err_idx   <= idx;
                    end
                    // match is settled on entry to DONE so it is already valid while done is high
                    if (nextState == DONE) begin
                        match <= !(err_valid || sampleMiss);
                    end else begin
                        idx       <= idx + 4'd1;
                        settleCnt <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/tabla_scan_ctrl.md
# tabla_scan_ctrl

Sequencer that exhaustively exercises one combinational truth-table block (the 3- or 4-input `Tabla*` family) by sweeping every input vector. It captures the block's `Y` for each vector into a truth-table register and compares the captured table against an expected table. It sits between a lab test harness or front-panel start button and a single instance of the function under test. The function's inputs are driven from `tbl_in` and its output is returned on `tbl_y`.

## Interface
Parameters:
- `N_IN`, 4, number of function inputs; legal values 3 or 4. `tbl_in[N_IN-1]` drives `inA`, and the next bits drive `inB`, `inC`, `inD` in that order.
- `SETTLE`, 1, number of cycles each vector is held before sampling; legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  starts a sweep; accepted only in IDLE.
- `expected`  in  16  expected truth table; bit i is Y for vector i. Sampled on the accepted `start`.
- `tbl_y`  in  1  output Y of the function under test.
- `tbl_in`  out  4  input vector to the function; bits above `N_IN-1` are driven 0.
- `busy`  out  1  high from the start edge through the DONE cycle.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `truth`  out  16  captured truth table; bits at index 2^N_IN and above are 0.
- `match`  out  1  valid when `done` is high and held until the next start: 1 if the captured table equals `expected` over the valid bits.
- `err_valid`  out  1  at least one mismatch occurred.
- `err_idx`  out  4  index of the first mismatching vector; 0 if there was no mismatch.

## Operation
The controller is a state machine with states IDLE, DRIVE, SAMPLE and DONE.
- **IDLE:**
  - `busy`=0.
  - If `start`=1: latch `expected`, clear `truth`, `err_valid`, `err_idx` and `match`, set idx=0, clear the settle counter, and go to DRIVE.
- **DRIVE:**
  - `tbl_in` = idx.
  - The settle counter counts up; after `SETTLE` cycles in DRIVE, go to SAMPLE.
- **SAMPLE:**
  - `truth[idx]` <= `tbl_y`.
  - If `tbl_y` != `expected[idx]` and `err_valid`=0: set `err_valid`=1 and `err_idx`=idx.
  - If idx = 2^N_IN−1, go to DONE; otherwise increment idx, clear the counter, and go to DRIVE.
  - `tbl_in` keeps holding idx during SAMPLE.
- **DONE:**
  - `done`=1 and `busy`=1.
  - `match` <= ~`err_valid`, evaluated including the SAMPLE result of the last vector.
  - Next state is IDLE unconditionally.
- **Comparison mask:** only bits 0..2^N_IN−1 of `expected` are compared; the upper bits are ignored.
- **`start` outside IDLE:** ignored in DRIVE, SAMPLE and DONE, including `start` asserted during the DONE cycle.
- **Retained results:** `truth`, `match`, `err_valid` and `err_idx` hold their values in IDLE until the next accepted `start`.
- **idx width:** idx is 4 bits. With `N_IN`=3, idx never exceeds 7.

## Timing
- **Reset (`rst_n`=0 at an edge):**
  - State goes to IDLE.
  - `tbl_in`=0, `busy`=0, `done`=0, `truth`=0, `match`=0, `err_valid`=0, `err_idx`=0.
  - Reset has priority over everything else, including mid-sweep. An aborted sweep leaves no partial results.
- **Start-to-done latency:** with the `start` edge at k, `busy`=1 from k and `done`=1 in the cycle following edge k + 2^N_IN·(SETTLE+1).
  - `N_IN`=4, `SETTLE`=1: 32 cycles.
  - `N_IN`=3, `SETTLE`=1: 16 cycles.
- **Vector hold:** vector i is on `tbl_in` for SETTLE+1 consecutive cycles. `tbl_y` is sampled at the end of the last of those cycles.
- **Earliest restart:** after `done`, the next `start` can be accepted in the first IDLE cycle, one cycle after `done`.

## Configuration
- `TABLA_SCAN_EARLY_STOP_EN` defined:
  - On the first mismatch in SAMPLE, go directly to DONE with `match`=0.
  - `truth` holds only the vectors sampled so far; the remaining bits are 0.
  - Latency becomes (`err_idx`+1)·(SETTLE+1) cycles.
- `TABLA_SCAN_EARLY_STOP_EN` undefined: the full sweep always runs, as described above.

## Test plan
- **Full match, 3 inputs:** `N_IN`=3, DUT Y=~B, `expected`=16'h0033, pulse `start`.
  - `done` 16 cycles after start; `truth`=16'h0033, `match`=1, `err_valid`=0, `err_idx`=0.
- **Full match, 4 inputs:** `N_IN`=4, DUT Y=C'D+B+AD, `expected`=16'hFAF2.
  - `done` after 32 cycles; `truth`=16'hFAF2, `match`=1.
- **Mismatch:** same DUT, `expected`=16'hFAF0.
  - `match`=0, `err_valid`=1, `err_idx`=1.
  - Early-stop build: `done` after 4 cycles, `truth`=16'h0002.
  - Full build: `truth`=16'hFAF2.
- **Reset mid-sweep:** `rst_n`=0 at cycle 10 of a sweep.
  - Next cycle: IDLE with all outputs 0.
  - A new `start` then completes normally.
- **Ignored start:** `start` held high through the whole sweep, including the DONE cycle.
  - Exactly one `done` pulse; a new sweep begins in the first IDLE cycle after it.
- **`SETTLE`=3:** `N_IN`=4.
  - Each `tbl_in` value is held 4 cycles; `done` after 64 cycles; results identical to the full-match 4-input case.
